// File: rtl/shift_arbiter.sv
// Round-robin front end for one shared combinational shifter (SLL/SRL/SRA).
// One request is in flight at a time: IDLE grants, EXEC captures sh_z, and RESP holds the result.
module shift_arbiter #(
    parameter int N    = 32,
    parameter int SHW  = 5,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [N*NREQ-1:0]   req_a,
    input  logic [N*NREQ-1:0]   req_b,
    output logic [1:0]          sh_op,
    output logic [N-1:0]        sh_a,
    output logic [SHW-1:0]      sh_b,
    input  logic [N-1:0]        sh_z,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [N-1:0]        resp_data,
    output logic [IDW-1:0]      resp_id,
    output logic                resp_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [1:0]         op_q, op_d;
    logic [N-1:0]       a_q, a_d;
    logic [SHW-1:0]     b_q, b_d;
    logic               resp_valid_q, resp_valid_d;
    logic [N-1:0]       resp_data_q, resp_data_d;
    logic [IDW-1:0]     resp_id_q, resp_id_d;
    logic               resp_err_q, resp_err_d;

    logic [1:0]         op_arr [NREQ];
    logic [N-1:0]       a_arr  [NREQ];
    logic [N-1:0]       b_arr  [NREQ];

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[2*gi +: 2];
        assign a_arr[gi]  = req_a[N*gi +: N];
        assign b_arr[gi]  = req_b[N*gi +: N];
    end

    // First pending requester after the last grant, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = (state_q == ST_IDLE) && !rst && grant_found
                               && (grant_idx == IDW'(gi));
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    op_d     = op_arr[grant_idx];
                    a_d      = a_arr[grant_idx];
                    // Shift amount is B mod N; upper B bits never reach the shifter.
                    b_d      = SHW'(b_arr[grant_idx] % N);
                    id_d     = grant_idx;
                    rr_ptr_d = grant_idx;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_data_d  = (op_q == 2'b11) ? a_q : sh_z;
                resp_err_d   = (op_q == 2'b11);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= IDW'(NREQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign sh_op      = op_q;
    assign sh_a       = a_q;
    assign sh_b       = b_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a transaction-level model is checked every cycle, and directed
// transactions are checked against hand-computed results.
module tb_shift_arbiter;
    localparam int N = 32, SHW = 5, NREQ = 4, IDW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [2*NREQ-1:0]   req_op;
    logic [N*NREQ-1:0]   req_a, req_b;
    logic [1:0]          sh_op;
    logic [N-1:0]        sh_a, sh_z;
    logic [SHW-1:0]      sh_b;
    logic                resp_valid, resp_ready;
    logic [N-1:0]        resp_data;
    logic [IDW-1:0]      resp_id;
    logic                resp_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.N(N), .SHW(SHW), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .sh_op(sh_op), .sh_a(sh_a), .sh_b(sh_b), .sh_z(sh_z),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
        .busy(busy)
    );

    function automatic logic [N-1:0] ref_shift(logic [1:0] op, logic [N-1:0] a, int amt);
        case (op)
            2'b00:   return a << amt;
            2'b01:   return a >> amt;
            2'b10:   return $unsigned($signed(a) >>> amt);
            default: return a;
        endcase
    endfunction

    // External shifter: garbage for op 11, so the DUT must substitute A itself.
    assign sh_z = (sh_op == 2'b11) ? ~sh_a : ref_shift(sh_op, sh_a, int'(sh_b));

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit             m_on = 1'b0;
    bit             m_inflight;
    int             m_age, m_ptr, m_id, m_rid, m_amt;
    logic [1:0]     m_op;
    logic [N-1:0]   m_a, m_data;
    bit             m_err;

    function automatic int pick();
        int g = -1;
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        return g;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        if (rst || m_inflight) return '0;
        g = pick();
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_on = 1'b1; m_inflight = 1'b0; m_age = 0; m_ptr = NREQ - 1;
            m_op = '0; m_a = '0; m_amt = 0; m_id = 0;
            m_data = '0; m_rid = 0; m_err = 1'b0;
        end else if (m_on) begin
            if (!m_inflight) begin
                g = pick();
                if (g >= 0) begin
                    m_inflight = 1'b1; m_age = 0; m_ptr = g; m_id = g;
                    m_op  = req_op[2*g +: 2];
                    m_a   = req_a[N*g +: N];
                    m_amt = int'(req_b[N*g +: N] % N);
                end
            end else if (m_age == 0) begin
                m_age  = 1;
                m_data = ref_shift(m_op, m_a, m_amt);
                m_rid  = m_id;
                m_err  = (m_op == 2'b11);
            end else if (resp_ready) begin
                m_inflight = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("req_ready",  64'(req_ready),  64'(exp_ready()));
            check("resp_valid", 64'(resp_valid), 64'(m_inflight && m_age == 1));
            check("busy",       64'(busy),       64'(m_inflight));
            check("resp_data",  64'(resp_data),  64'(m_data));
            check("resp_id",    64'(resp_id),    64'(m_rid));
            check("resp_err",   64'(resp_err),   64'(m_err));
            check("sh_op",      64'(sh_op),      64'(m_op));
            check("sh_a",       64'(sh_a),       64'(m_a));
            check("sh_b",       64'(sh_b),       64'(m_amt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic drive_req(int i, logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b);
        req_op[2*i +: 2] = op;
        req_a[N*i +: N]  = a;
        req_b[N*i +: N]  = b;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) check("wait_idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_txn(int i, logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b,
                          logic [N-1:0] exp_data, logic exp_err);
        bit got = 1'b0;
        int lat = 0;
        drive_req(i, op, a, b);
        req_valid  = NREQ'(1) << i;
        resp_ready = 1'b1;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        check("txn_grant", 64'(got), 64'(1));
        next();
        req_valid = '0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        check("txn_latency", 64'(lat), 64'(2));
        check("txn_data",    64'(resp_data), 64'(exp_data));
        check("txn_id",      64'(resp_id),   64'(i));
        check("txn_err",     64'(resp_err),  64'(exp_err));
        next();
        $display("txn req=%0d op=%0d a=%h b=%h -> data=%h err=%0d", i, op, a, b, exp_data, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gr[8], gc[8], rid[8];
        int gcount, rcount, c;
        bit got;

        rst = 1'b1; req_valid = '1; resp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) drive_req(i, 2'b00, N'(i + 1), N'(i));

        // Reset with every requester asking.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready),  64'(0));
        check("rst_valid", 64'(resp_valid), 64'(0));
        check("rst_busy",  64'(busy),       64'(0));
        next();
        rst = 1'b0;
        @(negedge clk);
        check("first_grant", 64'(req_ready), 64'(4'b0001));
        $display("reset released, first grant req_ready=%b", req_ready);
        next();
        req_valid = '0; resp_ready = 1'b1;
        wait_idle();
        next();

        do_txn(0, 2'b00, 32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 1'b0);
        do_txn(2, 2'b10, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0);
        do_txn(2, 2'b01, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0);
        do_txn(1, 2'b00, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
        do_txn(1, 2'b10, 32'h7000_0000, 32'h0000_001F, 32'h0000_0000, 1'b0);
        do_txn(3, 2'b10, 32'h8000_00F0, 32'hFFFF_FFE1, 32'hC000_0078, 1'b0);
        do_txn(3, 2'b01, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 1'b0);

        // Round robin with all requesters active; last grant was 3.
        for (int i = 0; i < NREQ; i++) drive_req(i, 2'b00, N'(32'h10 << i), N'(i));
        req_valid = '1; resp_ready = 1'b1;
        gcount = 0; rcount = 0; c = 0;
        while ((gcount < 5 || rcount < 5) && c < 60) begin
            @(negedge clk);
            c++;
            if (req_ready != '0 && gcount < 8) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gr[gcount] = i;
                gc[gcount] = c;
                gcount++;
            end
            if (resp_valid && resp_ready && rcount < 8) begin
                rid[rcount] = int'(resp_id);
                rcount++;
            end
        end
        next();
        req_valid = '0;
        check("rr_grant_count", 64'(gcount >= 5), 64'(1));
        check("rr_resp_count",  64'(rcount >= 5), 64'(1));
        for (int k = 0; k < 5; k++) begin
            if (k < gcount) begin
                check("rr_grant_order", 64'(gr[k]), 64'(k % NREQ));
                if (k > 0) check("rr_grant_gap", 64'(gc[k] - gc[k-1]), 64'(3));
                $display("rr grant %0d -> req %0d at cycle %0d", k, gr[k], gc[k]);
            end
            if (k < rcount) check("rr_resp_id", 64'(rid[k]), 64'(k % NREQ));
        end
        wait_idle();
        next();

        // Illegal op under backpressure; others keep asking.
        drive_req(1, 2'b11, 32'h1234_5678, 32'h0000_0007);
        req_valid = 4'b0010; resp_ready = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        check("bp_grant", 64'(got), 64'(1));
        next();
        req_valid = 4'b1111;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        check("bp_resp_seen", 64'(got), 64'(1));
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'(1));
            check("bp_data",  64'(resp_data),  64'(32'h1234_5678));
            check("bp_err",   64'(resp_err),   64'(1));
            check("bp_id",    64'(resp_id),    64'(1));
            check("bp_ready", 64'(req_ready),  64'(0));
        end
        $display("backpressure held 5 cycles data=%h err=%0d", resp_data, resp_err);
        next();
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_still_valid", 64'(resp_valid), 64'(1));
        @(negedge clk);
        check("bp_released",    64'(resp_valid), 64'(0));
        check("bp_next_grant",  64'(req_ready),  64'(4'b0100));
        next();
        req_valid = '0;
        wait_idle();
        next();

        // Reset while in EXEC drops the transaction.
        drive_req(0, 2'b00, 32'h0000_0003, 32'h0000_0002);
        drive_req(3, 2'b00, 32'h0000_0009, 32'h0000_0001);
        req_valid = 4'b0001; resp_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        check("mid_grant", 64'(got), 64'(1));
        next();
        rst = 1'b1; req_valid = 4'b1001;
        drive_req(0, 2'b00, 32'h0000_0005, 32'h0000_0002);
        @(negedge clk);
        check("mid_exec_busy", 64'(busy), 64'(1));
        next();
        rst = 1'b0;
        @(negedge clk);
        check("mid_valid", 64'(resp_valid), 64'(0));
        check("mid_busy",  64'(busy),       64'(0));
        check("mid_ready", 64'(req_ready),  64'(4'b0001));
        next();
        req_valid = '0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        check("mid_new_resp", 64'(got), 64'(1));
        check("mid_new_data", 64'(resp_data), 64'(32'h0000_0014));
        $display("after mid-op reset new result data=%h id=%0d", resp_data, resp_id);
        wait_idle();
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
